stopwatch_time_counter: RTL

- Time-base and counting stage for the stopwatch path.
- Divides the system clock into a 10 ms tick and counts centiseconds (0-99), seconds (0-59) and minutes (0-59) under run/stop/clear control.
- Drives i_msec/i_sec of the downstream digit divider for the FND display.
- o_msec is a 10-bit field but only ever carries 0..99 (hundredths of a second).

---
 rtl/stopwatch_time_counter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: divides clk into a TICK_HZ tick and counts mm:ss.cc under run/stop/clear.
// Optional lap freeze of the displayed time is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_time_counter #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_run_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic [9:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic       o_running,
  output logic       o_tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MSW   = 10;
  localparam int unsigned SW    = 6;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("stopwatch_time_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [MSW-1:0]   msec_q, msec_d;
  logic [SW-1:0]    sec_q, sec_d;
  logic [SW-1:0]    min_q, min_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;

  // Next-state: clear dominates; a tick in the stop-pulse cycle still lands.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    msec_d  = msec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    tick_d  = 1'b0;
    if (i_clear) begin
      state_d = ST_STOP;
      presc_d = '0;
      msec_d  = '0;
      sec_d   = '0;
      min_d   = '0;
    end else begin
      if (i_run_stop) begin
        state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
      end
      if (state_q == ST_RUN) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      // Full carry chain resolves in one edge.
      if (tick_d) begin
        if (msec_q == MSW'(99)) begin
          msec_d = '0;
          if (sec_q == SW'(59)) begin
            sec_d = '0;
            min_d = (min_q == SW'(59)) ? '0 : min_q + SW'(1);
          end else begin
            sec_d = sec_q + SW'(1);
          end
        end else begin
          msec_d = msec_q + MSW'(1);
        end
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      msec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      msec_q    <= msec_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      running_q <= running_d;
      tick_q    <= tick_d;
    end
  end

  assign o_running = running_q;
  assign o_tick    = tick_q;

`ifdef STOPWATCH_LAP_EN
  logic           hold_q, hold_d;
  logic [MSW-1:0] snap_msec_q, snap_msec_d;
  logic [SW-1:0]  snap_sec_q, snap_sec_d;
  logic [SW-1:0]  snap_min_q, snap_min_d;

  // Lap toggles only in RUN and loses to clear and run/stop in the same cycle.
  always_comb begin
    hold_d      = hold_q;
    snap_msec_d = snap_msec_q;
    snap_sec_d  = snap_sec_q;
    snap_min_d  = snap_min_q;
    if (i_clear) begin
      hold_d      = 1'b0;
      snap_msec_d = '0;
      snap_sec_d  = '0;
      snap_min_d  = '0;
    end else if (i_lap && !i_run_stop && state_q == ST_RUN) begin
      hold_d = !hold_q;
      if (!hold_q) begin
        snap_msec_d = msec_q;
        snap_sec_d  = sec_q;
        snap_min_d  = min_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= 1'b0;
      snap_msec_q <= '0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
    end else begin
      hold_q      <= hold_d;
      snap_msec_q <= snap_msec_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
    end
  end

  assign o_msec = hold_q ? snap_msec_q : msec_q;
  assign o_sec  = hold_q ? snap_sec_q  : sec_q;
  assign o_min  = hold_q ? snap_min_q  : min_q;
`else
  logic unused_lap;
  assign unused_lap = i_lap;

  assign o_msec = msec_q;
  assign o_sec  = sec_q;
  assign o_min  = min_q;
`endif

endmodule
